ascon_fsm_moore: RTL and testbench
==================================

# ascon_fsm_moore

Moore control FSM for the ASCON-128a style encryption datapath. It sequences five phases: initialisation (p12), associated data (p8), plaintext block 1 (p8), plaintext block 2 (p8) and finalisation (p12). It drives the state, cipher and tag register enables, the XOR controls and the round-counter controls. It reads back the external round counter value and never computes data itself.

## Interface
- No parameters.
- clock_i  in  1  system clock; all state changes on the rising edge.
- resetb_i  in  1  one clock; reset is synchronous and active-high.
- start_i  in  1  starts an encryption; sampled in IDLE and DONE.
- data_valid_i  in  1  next data block is present; sampled in END_* wait states.
- round_i  in  4  current round index from the external round counter.
- end_initialisation_o, end_associate_o, end_cipher1_o, end_cipher2_o, end_o  out  1 each  phase-complete flags.
- cipher_valid_o  out  1  cipher register holds a valid block.
- input_mode_o  out  1  1 selects initial state IV‖K‖N into the permutation; 0 selects the state register.
- en_reg_state_o  out  1  state register load enable.
- en_reg_tag_o  out  1  tag register load enable.
- en_reg_cipher_o  out  1  cipher register load enable.
- bypass_xor_end_o  out  1  1 bypasses the end-of-permutation XOR.
- mode_xor_key_o  out  1  end-XOR operand: 1 = 0*‖K, 0 = domain-separation 0*‖1.
- en_xor_begin_data_o  out  1  XOR data block into the rate before the round.
- en_xor_begin_key_o  out  1  XOR K‖0* into the capacity before the round.
- en_cpt_double_o  out  1  round counter increment enable.
- init_p12_o  out  1  load round counter with 0.
- init_p8_o  out  1  load round counter with 4.

## Operation
- Outputs are a pure function of the state register.
- All outputs default to 0, except bypass_xor_end_o, which defaults to 1.
- External counter contract: it loads on the edge after init_p12_o or init_p8_o, and increments on each edge while en_cpt_double_o = 1.
- The last round is always index 11.
- Per-phase sub-states (X = INIT, AD, C1, C2, FIN):
  - CONF_X: init_p12_o (INIT, FIN) or init_p8_o (AD, C1, C2).
  - FIRST_X: en_reg_state_o, en_cpt_double_o, plus phase-specific begin controls.
  - ROUNDS_X: en_reg_state_o, en_cpt_double_o.
  - LAST_X: en_reg_state_o, plus phase-specific end controls. en_cpt_double_o = 0.
- Phase-specific controls:
  - INIT: FIRST sets input_mode_o = 1. LAST sets bypass_xor_end_o = 0 and mode_xor_key_o = 1.
  - AD: FIRST sets en_xor_begin_data_o. LAST sets bypass_xor_end_o = 0 and mode_xor_key_o = 0.
  - C1, C2: FIRST sets en_xor_begin_data_o and en_reg_cipher_o. LAST keeps the bypass.
  - FIN: FIRST sets en_xor_begin_data_o, en_xor_begin_key_o and en_reg_cipher_o. LAST sets bypass_xor_end_o = 0, mode_xor_key_o = 1 and en_reg_tag_o.
- Wait states:
  - END_INIT: end_initialisation_o.
  - END_AD: end_associate_o.
  - END_C1: end_cipher1_o, cipher_valid_o.
  - END_C2: end_cipher2_o, cipher_valid_o.
  - DONE: end_o, cipher_valid_o.
- Transitions:
  - IDLE → CONF_INIT on start_i.
  - CONF_X → FIRST_X unconditionally.
  - FIRST_X → ROUNDS_X unconditionally.
  - ROUNDS_X → LAST_X when round_i >= 4'hA; otherwise stay.
  - LAST_X → its END/DONE state unconditionally.
  - END_INIT → CONF_AD, END_AD → CONF_C1, END_C1 → CONF_C2, END_C2 → CONF_FIN, each on data_valid_i; otherwise hold.
  - DONE → CONF_INIT on start_i; otherwise hold.
- start_i is ignored outside IDLE and DONE. data_valid_i is ignored outside the END_* wait states.
- Unused state encodings → IDLE.

## Timing
- Reset: the state becomes IDLE on the first rising edge with resetb_i = 1. All outputs become 0 and bypass_xor_end_o becomes 1.
- Reset mid-phase aborts immediately, with no completion flag.
- p12 phase:
  - Edges after the trigger edge: CONF 1 cycle, FIRST (round 0), ROUNDS 10 cycles (rounds 1–10), LAST (round 11).
  - The completion flag is high after 13 edges counting the trigger edge, i.e. the 13th edge from trigger.
- p8 phase:
  - CONF, FIRST (round 4), ROUNDS 6 cycles (rounds 5–10), LAST (round 11).
  - The flag is high 9 edges after the data_valid_i sampling edge.
- Completion flags stay high until the next accepted trigger edge.
- The flag drops one cycle after the trigger, when the FSM enters CONF.
- A one-cycle data_valid_i pulse is sufficient.
- If round_i stalls below 10, the FSM stays in ROUNDS_X indefinitely.

## Test plan
- Reset:
  - Stimulus: hold resetb_i = 1 for 2 edges, then release.
  - Required: all outputs 0, bypass_xor_end_o = 1, end_initialisation_o stays 0 without start_i.
- Initialisation:
  - Stimulus: 1-cycle start_i, with the bench modelling the counter.
  - Required: end_initialisation_o rises 13 edges later.
  - Required: input_mode_o high exactly 1 cycle, while the counter = 0.
  - Required: in LAST, mode_xor_key_o = 1 and bypass_xor_end_o = 0.
- AD phase:
  - Stimulus: data_valid_i pulse in END_INIT.
  - Required: init_p8_o for 1 cycle, en_xor_begin_data_o for 1 cycle, end-XOR with mode_xor_key_o = 0.
  - Required: end_associate_o rises 9 edges after the pulse.
- Cipher blocks:
  - Stimulus: two further pulses.
  - Required: en_reg_cipher_o for 1 cycle per block, bypass_xor_end_o stays 1.
  - Required: end_cipher1_o, then end_cipher2_o, each with cipher_valid_o.
- Finalisation:
  - Stimulus: a pulse in END_C2.
  - Required: en_xor_begin_key_o and en_xor_begin_data_o together for 1 cycle, then 12 rounds (0–11).
  - Required: en_reg_tag_o for 1 cycle, then end_o = 1 held.
- Restart and mid-run reset:
  - start_i in DONE: restarts initialisation.
  - Reset asserted during ROUNDS_AD: IDLE next edge.
  - data_valid_i during rounds: ignored.

Source files
------------

// File: rtl/ascon_fsm_moore.sv
// Moore sequencer for the ASCON-128a datapath: init (p12), AD (p8), two cipher
// blocks (p8) and finalisation (p12). Outputs are registered decodes of the state.
module ascon_fsm_moore (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic [3:0] round_i,
    output logic       end_initialisation_o,
    output logic       end_associate_o,
    output logic       end_cipher1_o,
    output logic       end_cipher2_o,
    output logic       end_o,
    output logic       cipher_valid_o,
    output logic       input_mode_o,
    output logic       en_reg_state_o,
    output logic       en_reg_tag_o,
    output logic       en_reg_cipher_o,
    output logic       bypass_xor_end_o,
    output logic       mode_xor_key_o,
    output logic       en_xor_begin_data_o,
    output logic       en_xor_begin_key_o,
    output logic       en_cpt_double_o,
    output logic       init_p12_o,
    output logic       init_p8_o
);

    typedef enum logic [4:0] {
        IDLE,
        CONF_INIT, FIRST_INIT, ROUNDS_INIT, LAST_INIT, END_INIT,
        CONF_AD,   FIRST_AD,   ROUNDS_AD,   LAST_AD,   END_AD,
        CONF_C1,   FIRST_C1,   ROUNDS_C1,   LAST_C1,   END_C1,
        CONF_C2,   FIRST_C2,   ROUNDS_C2,   LAST_C2,   END_C2,
        CONF_FIN,  FIRST_FIN,  ROUNDS_FIN,  LAST_FIN,  DONE
    } state_t;

    typedef struct packed {
        logic end_init;
        logic end_ad;
        logic end_c1;
        logic end_c2;
        logic end_all;
        logic cipher_valid;
        logic input_mode;
        logic en_state;
        logic en_tag;
        logic en_cipher;
        logic bypass;
        logic mode_key;
        logic xor_data;
        logic xor_key;
        logic en_cpt;
        logic p12;
        logic p8;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;

    function automatic state_t next_state(input state_t s, input logic start,
                                          input logic dv, input logic [3:0] round);
        state_t n;
        n = IDLE;
        case (s)
            IDLE:        n = start ? CONF_INIT : IDLE;
            CONF_INIT:   n = FIRST_INIT;
            FIRST_INIT:  n = ROUNDS_INIT;
            ROUNDS_INIT: n = (round >= 4'hA) ? LAST_INIT : ROUNDS_INIT;
            LAST_INIT:   n = END_INIT;
            END_INIT:    n = dv ? CONF_AD : END_INIT;
            CONF_AD:     n = FIRST_AD;
            FIRST_AD:    n = ROUNDS_AD;
            ROUNDS_AD:   n = (round >= 4'hA) ? LAST_AD : ROUNDS_AD;
            LAST_AD:     n = END_AD;
            END_AD:      n = dv ? CONF_C1 : END_AD;
            CONF_C1:     n = FIRST_C1;
            FIRST_C1:    n = ROUNDS_C1;
            ROUNDS_C1:   n = (round >= 4'hA) ? LAST_C1 : ROUNDS_C1;
            LAST_C1:     n = END_C1;
            END_C1:      n = dv ? CONF_C2 : END_C1;
            CONF_C2:     n = FIRST_C2;
            FIRST_C2:    n = ROUNDS_C2;
            ROUNDS_C2:   n = (round >= 4'hA) ? LAST_C2 : ROUNDS_C2;
            LAST_C2:     n = END_C2;
            END_C2:      n = dv ? CONF_FIN : END_C2;
            CONF_FIN:    n = FIRST_FIN;
            FIRST_FIN:   n = ROUNDS_FIN;
            ROUNDS_FIN:  n = (round >= 4'hA) ? LAST_FIN : ROUNDS_FIN;
            LAST_FIN:    n = DONE;
            DONE:        n = start ? CONF_INIT : DONE;
            default:     n = IDLE;
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        c.bypass = 1'b1;
        case (s)
            CONF_INIT, CONF_FIN:            c.p12 = 1'b1;
            CONF_AD, CONF_C1, CONF_C2:      c.p8  = 1'b1;
            FIRST_INIT: begin
                c.en_state = 1'b1; c.en_cpt = 1'b1; c.input_mode = 1'b1;
            end
            FIRST_AD: begin
                c.en_state = 1'b1; c.en_cpt = 1'b1; c.xor_data = 1'b1;
            end
            FIRST_C1, FIRST_C2: begin
                c.en_state = 1'b1; c.en_cpt = 1'b1; c.xor_data = 1'b1;
                c.en_cipher = 1'b1;
            end
            FIRST_FIN: begin
                c.en_state = 1'b1; c.en_cpt = 1'b1; c.xor_data = 1'b1;
                c.xor_key = 1'b1; c.en_cipher = 1'b1;
            end
            ROUNDS_INIT, ROUNDS_AD, ROUNDS_C1, ROUNDS_C2, ROUNDS_FIN: begin
                c.en_state = 1'b1; c.en_cpt = 1'b1;
            end
            LAST_INIT: begin
                c.en_state = 1'b1; c.bypass = 1'b0; c.mode_key = 1'b1;
            end
            LAST_AD: begin
                c.en_state = 1'b1; c.bypass = 1'b0;
            end
            LAST_C1, LAST_C2:               c.en_state = 1'b1;
            LAST_FIN: begin
                c.en_state = 1'b1; c.bypass = 1'b0; c.mode_key = 1'b1;
                c.en_tag = 1'b1;
            end
            END_INIT:                       c.end_init = 1'b1;
            END_AD:                         c.end_ad = 1'b1;
            END_C1: begin
                c.end_c1 = 1'b1; c.cipher_valid = 1'b1;
            end
            END_C2: begin
                c.end_c2 = 1'b1; c.cipher_valid = 1'b1;
            end
            DONE: begin
                c.end_all = 1'b1; c.cipher_valid = 1'b1;
            end
            default: c.bypass = 1'b1;
        endcase
        return c;
    endfunction

    assign state_nxt = next_state(state, start_i, data_valid_i, round_i);

    // Outputs are decoded from the next state and registered alongside it, so they
    // always equal a decode of the current state register.
    always_ff @(posedge clock_i) begin
        if (resetb_i) begin
            state <= IDLE;
            ctrl  <= decode(IDLE);
        end else begin
            state <= state_nxt;
            ctrl  <= decode(state_nxt);
        end
    end

    assign end_initialisation_o = ctrl.end_init;
    assign end_associate_o      = ctrl.end_ad;
    assign end_cipher1_o        = ctrl.end_c1;
    assign end_cipher2_o        = ctrl.end_c2;
    assign end_o                = ctrl.end_all;
    assign cipher_valid_o       = ctrl.cipher_valid;
    assign input_mode_o         = ctrl.input_mode;
    assign en_reg_state_o       = ctrl.en_state;
    assign en_reg_tag_o         = ctrl.en_tag;
    assign en_reg_cipher_o      = ctrl.en_cipher;
    assign bypass_xor_end_o     = ctrl.bypass;
    assign mode_xor_key_o       = ctrl.mode_key;
    assign en_xor_begin_data_o  = ctrl.xor_data;
    assign en_xor_begin_key_o   = ctrl.xor_key;
    assign en_cpt_double_o      = ctrl.en_cpt;
    assign init_p12_o           = ctrl.p12;
    assign init_p8_o            = ctrl.p8;

endmodule

// File: tb/tb_ascon_fsm_moore.sv
// Scoreboarded bench for ascon_fsm_moore: a phase/step reference model queues the
// expected control vector per cycle, a monitor compares after each rising edge.
module tb_ascon_fsm_moore;

    logic       clock_i = 1'b0;
    logic       resetb_i = 1'b0;
    logic       start_i = 1'b0;
    logic       data_valid_i = 1'b0;
    logic [3:0] round_i;
    logic end_initialisation_o, end_associate_o, end_cipher1_o, end_cipher2_o, end_o;
    logic cipher_valid_o, input_mode_o, en_reg_state_o, en_reg_tag_o, en_reg_cipher_o;
    logic bypass_xor_end_o, mode_xor_key_o, en_xor_begin_data_o, en_xor_begin_key_o;
    logic en_cpt_double_o, init_p12_o, init_p8_o;

    ascon_fsm_moore dut (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i),
        .data_valid_i(data_valid_i), .round_i(round_i),
        .end_initialisation_o(end_initialisation_o), .end_associate_o(end_associate_o),
        .end_cipher1_o(end_cipher1_o), .end_cipher2_o(end_cipher2_o), .end_o(end_o),
        .cipher_valid_o(cipher_valid_o), .input_mode_o(input_mode_o),
        .en_reg_state_o(en_reg_state_o), .en_reg_tag_o(en_reg_tag_o),
        .en_reg_cipher_o(en_reg_cipher_o), .bypass_xor_end_o(bypass_xor_end_o),
        .mode_xor_key_o(mode_xor_key_o), .en_xor_begin_data_o(en_xor_begin_data_o),
        .en_xor_begin_key_o(en_xor_begin_key_o), .en_cpt_double_o(en_cpt_double_o),
        .init_p12_o(init_p12_o), .init_p8_o(init_p8_o)
    );

    always #5 clock_i = ~clock_i;

    // External round counter, as the datapath would implement it.
    logic [3:0] cnt = 4'd0;
    always @(posedge clock_i) begin
        if (init_p12_o)           cnt <= 4'd0;
        else if (init_p8_o)       cnt <= 4'd4;
        else if (en_cpt_double_o) cnt <= cnt + 4'd1;
    end
    assign round_i = cnt;

    logic [16:0] actual;
    assign actual = {end_initialisation_o, end_associate_o, end_cipher1_o, end_cipher2_o,
                     end_o, cipher_valid_o, input_mode_o, en_reg_state_o, en_reg_tag_o,
                     en_reg_cipher_o, bypass_xor_end_o, mode_xor_key_o, en_xor_begin_data_o,
                     en_xor_begin_key_o, en_cpt_double_o, init_p12_o, init_p8_o};

    logic [16:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int cycle = 0;

    // Reference model: busy phase p (0=init,1=ad,2=c1,3=c2,4=fin) at step j since
    // the trigger edge, or waiting (-1 idle, 0..3 after phase p, 4 done).
    bit m_busy = 1'b0;
    int m_p = 0;
    int m_j = 0;
    int m_wait = -1;

    function automatic logic [16:0] exp_vec(input bit busy, input int p, input int j,
                                            input int wt);
        logic e_init, e_ad, e_c1, e_c2, e_end, cv, im, es, et, ec, byp, mk, xd, xk, cpt, l12, l8;
        int r;
        {e_init, e_ad, e_c1, e_c2, e_end, cv, im, es, et, ec, mk, xd, xk, cpt, l12, l8} = '0;
        byp = 1'b1;
        r = (p == 0 || p == 4) ? 10 : 6;
        if (busy) begin
            if (j == 1) begin
                if (p == 0 || p == 4) l12 = 1'b1; else l8 = 1'b1;
            end else if (j == 2) begin
                es = 1'b1; cpt = 1'b1;
                if (p == 0) im = 1'b1;
                if (p >= 1) xd = 1'b1;
                if (p >= 2) ec = 1'b1;
                if (p == 4) xk = 1'b1;
            end else if (j <= r + 2) begin
                es = 1'b1; cpt = 1'b1;
            end else begin
                es = 1'b1;
                if (p == 0 || p == 1 || p == 4) byp = 1'b0;
                if (p == 0 || p == 4) mk = 1'b1;
                if (p == 4) et = 1'b1;
            end
        end else begin
            case (wt)
                0: e_init = 1'b1;
                1: e_ad = 1'b1;
                2: begin e_c1 = 1'b1; cv = 1'b1; end
                3: begin e_c2 = 1'b1; cv = 1'b1; end
                4: begin e_end = 1'b1; cv = 1'b1; end
                default: ;
            endcase
        end
        return {e_init, e_ad, e_c1, e_c2, e_end, cv, im, es, et, ec, byp, mk, xd, xk, cpt, l12, l8};
    endfunction

    task automatic drive(input bit r, input bit s, input bit d);
        int rl;
        resetb_i = r; start_i = s; data_valid_i = d;
        if (r) begin
            m_busy = 1'b0; m_wait = -1;
        end else if (m_busy) begin
            m_j++;
            rl = (m_p == 0 || m_p == 4) ? 10 : 6;
            if (m_j == rl + 4) begin
                m_busy = 1'b0; m_wait = m_p;
            end
        end else if ((m_wait == -1 || m_wait == 4) && s) begin
            m_busy = 1'b1; m_p = 0; m_j = 1;
        end else if (m_wait >= 0 && m_wait <= 3 && d) begin
            m_busy = 1'b1; m_p = m_wait + 1; m_j = 1;
        end
        exp_q.push_back(exp_vec(m_busy, m_p, m_j, m_wait));
        @(negedge clock_i);
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clock_i);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                logic [16:0] e;
                e = exp_q.pop_front();
                total++;
                if (actual !== e) begin
                    bad++;
                    $display("FAIL outputs cycle=%0d got=%05h want=%05h", cycle, actual, e);
                end
            end
        end
    end

    initial begin
        @(negedge clock_i);
        drive(1, 0, 0);
        drive(1, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0);

        // Full encryption with one-cycle pulses, then restart from DONE.
        drive(0, 1, 0);
        for (int i = 0; i < 300 && !(!m_busy && m_wait == 4); i++) begin
            if (!m_busy && m_wait >= 0) drive(0, 0, 1);
            else drive(0, 0, 0);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0);
        drive(0, 1, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, 0);

        // Reset during AD rounds, with data_valid held high meanwhile.
        drive(0, 0, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 1);
        drive(1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1);

        // Random traffic, including stray pulses and occasional resets.
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0);

        @(posedge clock_i);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
